// File: rtl/core_pkg.sv
// Shared definitions for the ARM-subset core: command layout, ALU command
// encodings and the data payload carried from ID to EXE.
package core_pkg;

    // Decoded command word: {WB_EN, MEM_R_EN, MEM_W_EN, EXE_CMD[3:0], B, S}
    localparam int CMD_W      = 9;
    localparam int CMD_WB     = 8;
    localparam int CMD_MEM_R  = 7;
    localparam int CMD_MEM_W  = 6;
    localparam int CMD_EXE_HI = 5;
    localparam int CMD_EXE_LO = 2;
    localparam int CMD_B      = 1;
    localparam int CMD_S      = 0;

    // ALU command encodings driven on EXE_CMD
    typedef enum logic [3:0] {
        EXE_MOV = 4'b0001,
        EXE_ADD = 4'b0010,
        EXE_ADC = 4'b0011,
        EXE_SUB = 4'b0100,
        EXE_SBC = 4'b0101,
        EXE_AND = 4'b0110,
        EXE_ORR = 4'b0111,
        EXE_EOR = 4'b1000,
        EXE_MVN = 4'b1001
    } exe_cmd_e;

    // Data fields that travel with the instruction. exe_cmd lives here and
    // not with the control bits: an invalid slot still carries its ALU
    // command, only the side-effecting control bits are suppressed.
    typedef struct packed {
        logic [3:0]  exe_cmd;
        logic        imm;
        logic [11:0] shift_operand;
        logic [23:0] simm24;
        logic [3:0]  dest;
        logic [3:0]  src1;
        logic [3:0]  src2;
        logic [3:0]  sr;
    } id_exe_t;

    // Side-effecting control bits; all zero for a bubble
    typedef struct packed {
        logic wb_en;
        logic mem_r_en;
        logic mem_w_en;
        logic b;
        logic s;
    } id_exe_ctrl_t;

    // Unpack the control bits of a command word
    function automatic id_exe_ctrl_t cmd_ctrl(input logic [CMD_W-1:0] cmd);
        id_exe_ctrl_t c;
        c.wb_en    = cmd[CMD_WB];
        c.mem_r_en = cmd[CMD_MEM_R];
        c.mem_w_en = cmd[CMD_MEM_W];
        c.b        = cmd[CMD_B];
        c.s        = cmd[CMD_S];
        return c;
    endfunction

endpackage

// File: rtl/id_exe_stage_reg_sat_counter.sv
// Saturating up-counter with asynchronous active-low clear. Sticks at the
// all-ones value instead of wrapping so debug counts never lie low.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: step by one unless already at the ceiling
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Counter register, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/id_exe_stage_reg.sv
// ID->EXE pipeline register. Loads the decoded instruction each cycle,
// holds on a hazard freeze, and loads a bubble on a branch flush
// (flush beats freeze). Counts frozen cycles and inserted bubbles.
module id_exe_stage_reg
    import core_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              freeze,
    input  logic              flush,
    input  logic              valid_in,
    input  logic [8:0]        cmd_in,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [DATA_W-1:0] val_rn_in,
    input  logic [DATA_W-1:0] val_rm_in,
    input  logic              imm_in,
    input  logic [11:0]       shift_operand_in,
    input  logic [23:0]       simm24_in,
    input  logic [3:0]        dest_in,
    input  logic [3:0]        src1_in,
    input  logic [3:0]        src2_in,
    input  logic [3:0]        sr_in,
    output logic              valid_out,
    output logic              wb_en,
    output logic              mem_r_en,
    output logic              mem_w_en,
    output logic              b,
    output logic              s,
    output logic [3:0]        exe_cmd,
    output logic [DATA_W-1:0] pc,
    output logic [DATA_W-1:0] val_rn,
    output logic [DATA_W-1:0] val_rm,
    output logic              imm,
    output logic [11:0]       shift_operand,
    output logic [23:0]       simm24,
    output logic [3:0]        dest,
    output logic [3:0]        src1,
    output logic [3:0]        src2,
    output logic [3:0]        sr,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count
);

    // Handshake: there is no ready/valid back-pressure here. valid_in marks a
    // real instruction from ID; valid_out marks a real instruction in EXE.
    // freeze holds the slot, flush replaces it with a bubble (valid_out=0).

    id_exe_t           data_q;
    id_exe_t           data_d;
    id_exe_ctrl_t      ctrl_q;
    id_exe_ctrl_t      ctrl_d;
    logic              valid_q;
    logic [DATA_W-1:0] pc_q;
    logic [DATA_W-1:0] val_rn_q;
    logic [DATA_W-1:0] val_rm_q;

    // Gather ID-stage fields; control bits are zeroed for an empty slot
    always_comb begin
        data_d               = '0;
        data_d.exe_cmd       = cmd_in[CMD_EXE_HI:CMD_EXE_LO];
        data_d.imm           = imm_in;
        data_d.shift_operand = shift_operand_in;
        data_d.simm24        = simm24_in;
        data_d.dest          = dest_in;
        data_d.src1          = src1_in;
        data_d.src2          = src2_in;
        data_d.sr            = sr_in;
        ctrl_d               = valid_in ? cmd_ctrl(cmd_in) : '0;
    end

    // Stage register: flush > freeze > load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q   <= '0;
            ctrl_q   <= '0;
            valid_q  <= 1'b0;
            pc_q     <= '0;
            val_rn_q <= '0;
            val_rm_q <= '0;
        end else if (flush) begin
            data_q   <= '0;
            ctrl_q   <= '0;
            valid_q  <= 1'b0;
            pc_q     <= '0;
            val_rn_q <= '0;
            val_rm_q <= '0;
        end else if (!freeze) begin
            data_q   <= data_d;
            ctrl_q   <= ctrl_d;
            valid_q  <= valid_in;
            pc_q     <= pc_in;
            val_rn_q <= val_rn_in;
            val_rm_q <= val_rm_in;
        end
    end

    // Debug counters: a flush cycle is never also counted as a stall
    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (freeze & ~flush),
        .count (stall_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush),
        .count (flush_count)
    );

    assign valid_out     = valid_q;
    assign wb_en         = ctrl_q.wb_en;
    assign mem_r_en      = ctrl_q.mem_r_en;
    assign mem_w_en      = ctrl_q.mem_w_en;
    assign b             = ctrl_q.b;
    assign s             = ctrl_q.s;
    assign exe_cmd       = data_q.exe_cmd;
    assign pc            = pc_q;
    assign val_rn        = val_rn_q;
    assign val_rm        = val_rm_q;
    assign imm           = data_q.imm;
    assign shift_operand = data_q.shift_operand;
    assign simm24        = data_q.simm24;
    assign dest          = data_q.dest;
    assign src1          = data_q.src1;
    assign src2          = data_q.src2;
    assign sr            = data_q.sr;

endmodule

// File: tb/tb_id_exe_stage_reg.sv
// Bench for id_exe_stage_reg: reset/async-clear sequence, a table of
// directed load/freeze/flush vectors, and a saturation run on a 2-bit
// counter instance.
module tb_id_exe_stage_reg;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic        freeze, flush, valid_in, imm_in;
    logic [8:0]  cmd_in;
    logic [31:0] pc_in, val_rn_in, val_rm_in;
    logic [11:0] shift_operand_in;
    logic [23:0] simm24_in;
    logic [3:0]  dest_in, src1_in, src2_in, sr_in;

    logic        valid_out, wb_en, mem_r_en, mem_w_en, b, s, imm;
    logic [3:0]  exe_cmd, dest, src1, src2, sr;
    logic [31:0] pc, val_rn, val_rm;
    logic [11:0] shift_operand;
    logic [23:0] simm24;
    logic [15:0] stall_count, flush_count;

    // second instance: narrow counters for the saturation check
    logic        freeze2;
    logic        flush2;
    logic        valid_out2, wb_en2, mem_r_en2, mem_w_en2, b2, s2, imm2;
    logic [3:0]  exe_cmd2, dest2, src1_2, src2_2, sr2;
    logic [31:0] pc2, val_rn2, val_rm2;
    logic [11:0] shift_operand2;
    logic [23:0] simm24_2;
    logic [1:0]  stall_count2, flush_count2;

    id_exe_stage_reg #(.DATA_W(32), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush),
        .valid_in(valid_in), .cmd_in(cmd_in), .pc_in(pc_in),
        .val_rn_in(val_rn_in), .val_rm_in(val_rm_in), .imm_in(imm_in),
        .shift_operand_in(shift_operand_in), .simm24_in(simm24_in),
        .dest_in(dest_in), .src1_in(src1_in), .src2_in(src2_in), .sr_in(sr_in),
        .valid_out(valid_out), .wb_en(wb_en), .mem_r_en(mem_r_en),
        .mem_w_en(mem_w_en), .b(b), .s(s), .exe_cmd(exe_cmd), .pc(pc),
        .val_rn(val_rn), .val_rm(val_rm), .imm(imm),
        .shift_operand(shift_operand), .simm24(simm24), .dest(dest),
        .src1(src1), .src2(src2), .sr(sr),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    id_exe_stage_reg #(.DATA_W(32), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .freeze(freeze2), .flush(flush2),
        .valid_in(valid_in), .cmd_in(cmd_in), .pc_in(pc_in),
        .val_rn_in(val_rn_in), .val_rm_in(val_rm_in), .imm_in(imm_in),
        .shift_operand_in(shift_operand_in), .simm24_in(simm24_in),
        .dest_in(dest_in), .src1_in(src1_in), .src2_in(src2_in), .sr_in(sr_in),
        .valid_out(valid_out2), .wb_en(wb_en2), .mem_r_en(mem_r_en2),
        .mem_w_en(mem_w_en2), .b(b2), .s(s2), .exe_cmd(exe_cmd2), .pc(pc2),
        .val_rn(val_rn2), .val_rm(val_rm2), .imm(imm2),
        .shift_operand(shift_operand2), .simm24(simm24_2), .dest(dest2),
        .src1(src1_2), .src2(src2_2), .sr(sr2),
        .stall_count(stall_count2), .flush_count(flush_count2)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        flush;
        logic        freeze;
        logic        valid;
        logic [8:0]  cmd;
        logic [31:0] pc;
        logic [31:0] rn;
        logic [31:0] d;      // seed for rm / imm / shift / simm24 / src1 / src2 / sr
        logic [3:0]  dst;
        logic        e_valid;
        logic [4:0]  e_ctrl; // {wb_en, mem_r_en, mem_w_en, b, s}
        logic [3:0]  e_exe;
        logic [31:0] e_pc;
        logic [31:0] e_rn;
        logic [31:0] e_d;
        logic [3:0]  e_dst;
        logic [15:0] e_stall;
        logic [15:0] e_flush;
    } vec_t;

    vec_t vecs[11];

    function automatic vec_t mk(
        input logic fl, input logic fr, input logic v, input logic [8:0] c,
        input logic [31:0] p, input logic [31:0] r, input logic [31:0] dd, input logic [3:0] ds,
        input logic ev, input logic [4:0] ec, input logic [3:0] ee, input logic [31:0] ep,
        input logic [31:0] er, input logic [31:0] ed, input logic [3:0] eds,
        input logic [15:0] es, input logic [15:0] ef);
        vec_t t;
        t.flush = fl; t.freeze = fr; t.valid = v; t.cmd = c; t.pc = p; t.rn = r;
        t.d = dd; t.dst = ds; t.e_valid = ev; t.e_ctrl = ec; t.e_exe = ee;
        t.e_pc = ep; t.e_rn = er; t.e_d = ed; t.e_dst = eds;
        t.e_stall = es; t.e_flush = ef;
        return t;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic fl, input logic fr, input logic v, input logic [8:0] c,
                         input logic [31:0] p, input logic [31:0] r, input logic [31:0] dd,
                         input logic [3:0] ds);
        flush            = fl;
        freeze           = fr;
        valid_in         = v;
        cmd_in           = c;
        pc_in            = p;
        val_rn_in        = r;
        val_rm_in        = dd;
        imm_in           = dd[0];
        shift_operand_in = dd[11:0];
        simm24_in        = dd[23:0];
        dest_in          = ds;
        src1_in          = dd[3:0];
        src2_in          = dd[7:4];
        sr_in            = dd[11:8];
    endtask

    task automatic check_vec(input int i, input vec_t t);
        string p;
        p = $sformatf("v%0d", i);
        chk({p, ".valid_out"}, {31'd0, valid_out}, {31'd0, t.e_valid});
        chk({p, ".ctrl"}, {27'd0, wb_en, mem_r_en, mem_w_en, b, s}, {27'd0, t.e_ctrl});
        chk({p, ".exe_cmd"}, {28'd0, exe_cmd}, {28'd0, t.e_exe});
        chk({p, ".pc"}, pc, t.e_pc);
        chk({p, ".val_rn"}, val_rn, t.e_rn);
        chk({p, ".val_rm"}, val_rm, t.e_d);
        chk({p, ".imm"}, {31'd0, imm}, {31'd0, t.e_d[0]});
        chk({p, ".shift_operand"}, {20'd0, shift_operand}, {20'd0, t.e_d[11:0]});
        chk({p, ".simm24"}, {8'd0, simm24}, {8'd0, t.e_d[23:0]});
        chk({p, ".dest"}, {28'd0, dest}, {28'd0, t.e_dst});
        chk({p, ".src1"}, {28'd0, src1}, {28'd0, t.e_d[3:0]});
        chk({p, ".src2"}, {28'd0, src2}, {28'd0, t.e_d[7:4]});
        chk({p, ".sr"}, {28'd0, sr}, {28'd0, t.e_d[11:8]});
        chk({p, ".stall_count"}, {16'd0, stall_count}, {16'd0, t.e_stall});
        chk({p, ".flush_count"}, {16'd0, flush_count}, {16'd0, t.e_flush});
    endtask

    // ---------------- test ----------------
    logic [1:0] sat_exp[5];

    initial begin
        // ADD,S = 9'h109   STR(ADD addr) = 9'h048   B = 9'h002
        // MVN,S = 9'h125   LDR = 9'h188
        //              fl    fr    v     cmd     pc      rn            d              dst
        //              ev    ctrl      exe    epc     ern           ed             edst  stall flush
        vecs[0]  = mk(1'b0, 1'b0, 1'b1, 9'h109, 32'd4,  32'd5,        32'h1234_5678, 4'd1,
                      1'b1, 5'b10001, 4'h2, 32'd4,  32'd5,        32'h1234_5678, 4'd1, 16'd0, 16'd0);
        vecs[1]  = mk(1'b0, 1'b0, 1'b1, 9'h048, 32'd8,  32'hA,        32'h0BAD_F00D, 4'd2,
                      1'b1, 5'b00100, 4'h2, 32'd8,  32'hA,        32'h0BAD_F00D, 4'd2, 16'd0, 16'd0);
        vecs[2]  = mk(1'b0, 1'b1, 1'b1, 9'h1FF, 32'd100, 32'd99,      32'h5555_AAAA, 4'd9,
                      1'b1, 5'b00100, 4'h2, 32'd8,  32'hA,        32'h0BAD_F00D, 4'd2, 16'd1, 16'd0);
        vecs[3]  = mk(1'b0, 1'b1, 1'b0, 9'h000, 32'd101, 32'd98,      32'hAAAA_5555, 4'd7,
                      1'b1, 5'b00100, 4'h2, 32'd8,  32'hA,        32'h0BAD_F00D, 4'd2, 16'd2, 16'd0);
        vecs[4]  = mk(1'b0, 1'b1, 1'b1, 9'h188, 32'd102, 32'd97,      32'hFFFF_FFFF, 4'd15,
                      1'b1, 5'b00100, 4'h2, 32'd8,  32'hA,        32'h0BAD_F00D, 4'd2, 16'd3, 16'd0);
        vecs[5]  = mk(1'b1, 1'b1, 1'b1, 9'h1FF, 32'd200, 32'd33,      32'h7777_7777, 4'd6,
                      1'b0, 5'b00000, 4'h0, 32'd0,  32'd0,        32'd0,         4'd0, 16'd3, 16'd1);
        vecs[6]  = mk(1'b0, 1'b0, 1'b0, 9'h1FF, 32'd12, 32'd7,        32'hCAFE_BEEF, 4'd3,
                      1'b0, 5'b00000, 4'hF, 32'd12, 32'd7,        32'hCAFE_BEEF, 4'd3, 16'd3, 16'd1);
        vecs[7]  = mk(1'b0, 1'b0, 1'b1, 9'h002, 32'd16, 32'd0,        32'd1,         4'd0,
                      1'b1, 5'b00010, 4'h0, 32'd16, 32'd0,        32'd1,         4'd0, 16'd3, 16'd1);
        vecs[8]  = mk(1'b1, 1'b0, 1'b1, 9'h002, 32'd20, 32'd1,        32'd2,         4'd1,
                      1'b0, 5'b00000, 4'h0, 32'd0,  32'd0,        32'd0,         4'd0, 16'd3, 16'd2);
        vecs[9]  = mk(1'b0, 1'b0, 1'b1, 9'h125, 32'd20, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd15,
                      1'b1, 5'b10001, 4'h9, 32'd20, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd15, 16'd3, 16'd2);
        vecs[10] = mk(1'b0, 1'b0, 1'b1, 9'h188, 32'd24, 32'h40,       32'h0000_0F0F, 4'd4,
                      1'b1, 5'b11000, 4'h2, 32'd24, 32'h40,       32'h0000_0F0F, 4'd4, 16'd3, 16'd2);
        sat_exp[0] = 2'd1; sat_exp[1] = 2'd2; sat_exp[2] = 2'd3;
        sat_exp[3] = 2'd3; sat_exp[4] = 2'd3;

        freeze2 = 1'b0;
        flush2  = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 9'h000, 32'd0, 32'd0, 32'd0, 4'd0);

        // initial reset, outputs zero while held
        repeat (2) cycle();
        chk("rst.valid_out", {31'd0, valid_out}, 32'd0);
        chk("rst.pc", pc, 32'd0);
        rst_n = 1'b1;

        // load a nonzero slot, then freeze one cycle
        drive(1'b0, 1'b0, 1'b1, 9'h1FF, 32'hDEAD_BEEF, 32'h1111_1111, 32'hFFFF_FFFF, 4'hF);
        cycle();
        freeze = 1'b1;
        cycle();
        chk("pre_rst.valid_out", {31'd0, valid_out}, 32'd1);
        chk("pre_rst.stall_count", {16'd0, stall_count}, 32'd1);
        chk("pre_rst.pc", pc, 32'hDEAD_BEEF);

        // async reset mid-cycle: outputs clear without a clock edge
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst.valid_out", {31'd0, valid_out}, 32'd0);
        chk("async_rst.ctrl", {27'd0, wb_en, mem_r_en, mem_w_en, b, s}, 32'd0);
        chk("async_rst.exe_cmd", {28'd0, exe_cmd}, 32'd0);
        chk("async_rst.pc", pc, 32'd0);
        chk("async_rst.val_rn", val_rn, 32'd0);
        chk("async_rst.val_rm", val_rm, 32'd0);
        chk("async_rst.dest", {28'd0, dest}, 32'd0);
        chk("async_rst.stall_count", {16'd0, stall_count}, 32'd0);
        chk("async_rst.flush_count", {16'd0, flush_count}, 32'd0);

        // release reset while frozen: zeros held, stall counts from 0
        #1;
        rst_n = 1'b1;
        cycle();
        chk("rel_frz.valid_out", {31'd0, valid_out}, 32'd0);
        chk("rel_frz.pc", pc, 32'd0);
        chk("rel_frz.wb_en", {31'd0, wb_en}, 32'd0);
        chk("rel_frz.stall_count", {16'd0, stall_count}, 32'd1);

        // clean reset before the vector table
        #2;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 9'h000, 32'd0, 32'd0, 32'd0, 4'd0);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].flush, vecs[i].freeze, vecs[i].valid, vecs[i].cmd,
                  vecs[i].pc, vecs[i].rn, vecs[i].d, vecs[i].dst);
            cycle();
            check_vec(i, vecs[i]);
        end

        // saturation on the 2-bit counter instance
        drive(1'b0, 1'b0, 1'b0, 9'h000, 32'd0, 32'd0, 32'd0, 4'd0);
        chk("sat.start", {30'd0, stall_count2}, 32'd0);
        freeze2 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk($sformatf("sat.stall_count[%0d]", i), {30'd0, stall_count2}, {30'd0, sat_exp[i]});
        end
        freeze2 = 1'b0;
        chk("sat.flush_count", {30'd0, flush_count2}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
